// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, parity selector encodings and legal prescale values.
// STOP2 exists only when UART_TX_STOP2_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_STOP2_EN
    ,
    STOP2
`endif
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [4:0] PRESCALE_X8  = 5'd7;
  localparam logic [4:0] PRESCALE_X16 = 5'd15;
  localparam logic [4:0] PRESCALE_X32 = 5'd31;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity over a data word; par_typ selects even or odd.
// Shared with the RX path for its parity check.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  always_comb begin
    parity = (^data) ^ (par_typ == PAR_ODD);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, stop; bit = prescale+1 clocks.
// Optional second stop bit enabled by defining UART_TX_STOP2_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [4:0]            prescale,
`ifdef UART_TX_STOP2_EN
  input  logic                  stop2,
`endif
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state, state_next;
  logic [4:0]            cnt, cnt_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;
  logic [4:0]            presc_q;
`ifdef UART_TX_STOP2_EN
  logic                  stop2_q;
`endif
  logic                  accept, bit_done, parity_bit, tx_next, busy_next;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .parity  (parity_bit)
  );

  always_comb begin
    accept     = (state == IDLE) && data_valid;
    bit_done   = (cnt == presc_q);
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    if (state != IDLE) cnt_next = bit_done ? '0 : cnt + 5'd1;

    unique case (state)
      IDLE:   if (data_valid) begin
                state_next = START;
                cnt_next   = '0;
                idx_next   = '0;
              end
      START:  if (bit_done) begin
                state_next = DATA;
                idx_next   = '0;
              end
      DATA:   if (bit_done) begin
                if (idx == IDX_LAST) state_next = par_en_q ? PARITY : STOP;
                else                 idx_next   = idx + 1'b1;
              end
      PARITY: if (bit_done) state_next = STOP;
`ifdef UART_TX_STOP2_EN
      STOP:   if (bit_done) state_next = stop2_q ? STOP2 : IDLE;
      STOP2:  if (bit_done) state_next = IDLE;
`else
      STOP:   if (bit_done) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    // At acceptance the shadow byte is not loaded yet, but START drives 0 regardless.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[idx_next];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= 1'b0;
`endif
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      idx    <= idx_next;
      tx_out <= tx_next;
      busy   <= busy_next;
      if (accept) begin
        data_q    <= p_data;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        presc_q   <= prescale;
`ifdef UART_TX_STOP2_EN
        stop2_q   <= stop2;
`endif
      end
    end
  end

endmodule
